fir_input_sequencer: RTL and testbench
======================================

Name: fir_input_sequencer

Overview:
Sits directly upstream of the FIR controller. It buffers incoming 16-bit samples in a small FIFO and sequences coefficient loads. It generates the controller's data_ready and load_coeff handshakes, timed to the controller's modwait/err behaviour. Samples are never lost while the controller is busy, and coefficient reloads are never interleaved with a sample computation.

Parameters:
DATA_W, 16, sample/coefficient word width
DEPTH, 4, sample FIFO depth (power of 2, >=2)
NUM_COEFF, 4, coefficients per set

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
sample_valid  in  1  upstream push request
sample_data  in  DATA_W  upstream sample
sample_ready  out  1  FIFO not full (registered)
new_coeff_set  in  1  level: coefficient set pending in register file
coeff_index  out  2  index of coefficient currently being loaded
coeff_done  out  1  one-cycle pulse after last coefficient load completes
modwait  in  1  controller busy (controller state != IDLE)
err  in  1  controller error flag (error-idle)
data_ready  out  1  to controller dr
load_coeff  out  1  to controller lc
sample_out  out  DATA_W  FIFO head, valid while data_ready=1
fifo_count  out  3  entries held (0..DEPTH)
overrun  out  1  sticky: push attempted while full
clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset values: FIFO empty, fifo_count=0, sample_ready=1, data_ready=0, load_coeff=0, coeff_index=0, coeff_done=0, overrun=0, sample_out=0, state=IDLE. Reset mid-handshake aborts the handshake and discards FIFO contents.
- FIFO push: occurs when sample_valid && sample_ready. sample_ready=(fifo_count!=DEPTH), registered.
- Push while full: sample is dropped and overrun is set. Simultaneous pop does not make room that cycle.
- overrun: clear_overrun clears it. If clear_overrun and a new overrun occur in the same cycle, set wins.
- FIFO pop: occurs on the last DR2 cycle. Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, DR1, DR2, SWAIT, LC, LCWAIT, CDONE.
- IDLE: when modwait=0, or err=1 (controller in error-idle):
  - if new_coeff_set=1 -> LC. Coefficients have priority over samples.
  - else if fifo_count!=0 -> DR1.
  - else stay.
- DR1: data_ready=1 -> DR2 unconditionally.
- DR2: data_ready=1, pop FIFO -> SWAIT. The controller samples dr in both its IDLE and LOADD cycles, so dr is exactly 2 cycles. sample_out holds the same head value in both cycles.
- SWAIT: -> IDLE when modwait=0 or err=1. The first SWAIT cycle always sees modwait=1 from a healthy controller.
- LC: load_coeff=1 for exactly one cycle, coeff_index valid -> LCWAIT.
- LCWAIT: wait for modwait=0 or err=1.
  - If coeff_index==NUM_COEFF-1: -> CDONE.
  - Else: coeff_index+1, -> LC.
- CDONE: coeff_done=1 for one cycle, coeff_index returns to 0 -> IDLE.
  - The register file deasserts new_coeff_set upon coeff_done.
  - new_coeff_set still high on the IDLE cycle after CDONE starts a fresh 4-coefficient load.
- Changes to new_coeff_set during LC/LCWAIT are ignored until CDONE.
- Samples pushed during a coefficient load are buffered, not dropped unless the FIFO is full.
- Outputs are Moore (decoded from registered state), except sample_ready, which is a registered flag.

Test Plan:
- Reset, push 0x1234 with modwait=0 -> data_ready high for exactly the 2 cycles after the push cycle's successor; sample_out=0x1234 both cycles; fifo_count 1->0 after DR2.
- Push 5 samples back-to-back with modwait held 1 -> sample_ready drops after 4th push, 5th dropped, overrun=1, fifo_count=4; clear_overrun -> overrun=0.
- new_coeff_set=1 with 2 samples queued, modwait=0 -> four 1-cycle load_coeff pulses, coeff_index 0,1,2,3, each waiting for modwait low; coeff_done pulse; then data_ready pairs for both samples in order.
- During SWAIT, modwait stays 1 and err rises -> FSM returns to IDLE next cycle; next queued sample issued with data_ready.
- Push and pop in same cycle with fifo_count=2 -> fifo_count stays 2; FIFO order preserved across pointer wrap over 10 samples (values 0x0001..0x000A).
- Assert n_rst low during DR1 -> data_ready=0 immediately, fifo_count=0, sample_ready=1, state IDLE after release.

Source files
------------

// File: rtl/fir_input_sequencer.sv
// fir_input_sequencer
//
// Sits directly upstream of the FIR controller. Incoming samples are buffered in
// a small FIFO. The block drives the controller's dr (data_ready) and lc (load_coeff)
// handshakes. Coefficient loads take priority over samples. A coefficient load is
// never interleaved with a sample computation.
//
// Ports:
//   clk, n_rst       clock, asynchronous active-low reset
//   sample_valid     upstream push request
//   sample_data      upstream sample
//   sample_ready     FIFO not full (registered flag)
//   new_coeff_set    level: a coefficient set is pending in the register file
//   coeff_index      index of the coefficient currently being loaded
//   coeff_done       one-cycle pulse after the last coefficient load completes
//   modwait          controller busy
//   err              controller error flag (error-idle)
//   data_ready       to controller dr
//   load_coeff       to controller lc
//   sample_out       FIFO head; valid while data_ready=1, otherwise 0
//   fifo_count       entries held (0..DEPTH)
//   overrun          sticky: a push was attempted while the FIFO was full
//   clear_overrun    synchronous clear of overrun (a new overrun in the same cycle wins)
module fir_input_sequencer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_COEFF = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         sample_valid,
  input  logic [DATA_W-1:0]            sample_data,
  output logic                         sample_ready,
  input  logic                         new_coeff_set,
  output logic [1:0]                   coeff_index,
  output logic                         coeff_done,
  input  logic                         modwait,
  input  logic                         err,
  output logic                         data_ready,
  output logic                         load_coeff,
  output logic [DATA_W-1:0]            sample_out,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overrun,
  input  logic                         clear_overrun
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [1:0]      LastIdx = 2'(NUM_COEFF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDr1,
    StDr2,
    StSwait,
    StLc,
    StLcwait,
    StCdone
  } state_e;

  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              ready_q;
  logic              overrun_q, overrun_d;

  logic push, drop, pop, ctrl_free;

  // The controller can accept a new dr/lc when it is idle or parked in error-idle.
  assign ctrl_free = !modwait || err;

  // ready_q reflects last cycle's count, so a same-cycle pop never frees a slot
  // for a push into a full FIFO.
  assign push = sample_valid && ready_q;
  assign drop = sample_valid && !ready_q;
  assign pop  = (state_q == StDr2);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      ready_q   <= (count_d != CntFull);
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_data;
  end

  // ---------------------------------------------------------------------------
  // Handshake sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_free) begin
          if (new_coeff_set) begin
            state_d = StLc;
          end else if (count_q != '0) begin
            state_d = StDr1;
          end
        end
      end
      // dr is held for two cycles because the controller samples it in both its
      // IDLE and LOADD states.
      StDr1:   state_d = StDr2;
      StDr2:   state_d = StSwait;
      StSwait: begin
        if (ctrl_free) state_d = StIdle;
      end
      StLc:    state_d = StLcwait;
      StLcwait: begin
        if (ctrl_free) begin
          if (idx_q == LastIdx) begin
            state_d = StCdone;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StLc;
          end
        end
      end
      StCdone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: begin
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore, except the registered sample_ready flag)
  // ---------------------------------------------------------------------------
  assign data_ready   = (state_q == StDr1) || (state_q == StDr2);
  assign load_coeff   = (state_q == StLc);
  assign coeff_done   = (state_q == StCdone);
  assign coeff_index  = idx_q;
  assign sample_out   = data_ready ? mem_q[rd_ptr_q] : '0;
  assign sample_ready = ready_q;
  assign fifo_count   = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fir_input_sequencer.sv
module tb_fir_input_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        new_coeff_set;
  logic [1:0]  coeff_index;
  logic        coeff_done;
  logic        modwait;
  logic        err;
  logic        data_ready;
  logic        load_coeff;
  logic [15:0] sample_out;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        clear_overrun;

  // Controller stand-in: manual modwait, or a model that stays busy for three
  // cycles after the last cycle it saw dr or lc.
  logic auto_ctrl;
  logic mw_man;
  int   busy;
  assign modwait = auto_ctrl ? (busy != 0) : mw_man;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ev_q[$];
  logic [31:0] exp_q[$];
  logic        prev_dr;
  logic        prev_lc;
  int          dr_len;
  logic [15:0] dr_val;

  fir_input_sequencer #(
    .DATA_W   (16),
    .DEPTH    (4),
    .NUM_COEFF(4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .new_coeff_set(new_coeff_set),
    .coeff_index  (coeff_index),
    .coeff_done   (coeff_done),
    .modwait      (modwait),
    .err          (err),
    .data_ready   (data_ready),
    .load_coeff   (load_coeff),
    .sample_out   (sample_out),
    .fifo_count   (fifo_count),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample 1 time unit after the edge, log events, run the
  // controller model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (data_ready) begin
      if (!prev_dr) begin
        dr_val = sample_out;
        dr_len = 1;
        ev_q.push_back({16'h0, sample_out});
      end else begin
        dr_len++;
        check_eq("dr_hold_value", {16'h0, sample_out}, {16'h0, dr_val});
      end
    end else if (prev_dr) begin
      check_eq("dr_width", dr_len, 2);
    end
    prev_dr = data_ready;
    if (load_coeff) begin
      check_eq("lc_width", {31'h0, prev_lc}, 32'h0);
      ev_q.push_back(32'h0001_0000 | {30'h0, coeff_index});
    end
    prev_lc = load_coeff;
    if (coeff_done) begin
      ev_q.push_back(32'h0002_0000);
      new_coeff_set = 1'b0;
    end
    if (load_coeff || data_ready) busy = 3;
    else if (busy > 0) busy--;
  endtask

  task automatic check_events(input string tag);
    check_eq({tag, "_len"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s[%0d]", tag, i), (i < ev_q.size()) ? ev_q[i] : 32'hFFFF_FFFF,
               exp_q[i]);
    end
  endtask

  task automatic push_one(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; sample_valid = 1'b0; sample_data = '0; new_coeff_set = 1'b0;
    err = 1'b0; clear_overrun = 1'b0; auto_ctrl = 1'b0; mw_man = 1'b0; busy = 0;
    prev_dr = 1'b0; prev_lc = 1'b0; dr_len = 0; dr_val = '0;
    #12;
    n_rst = 1'b1;

    // Reset state
    check_eq("rst_count", {29'h0, fifo_count}, 0);
    check_eq("rst_ready", {31'h0, sample_ready}, 1);
    check_eq("rst_dr", {31'h0, data_ready}, 0);
    check_eq("rst_lc", {31'h0, load_coeff}, 0);
    check_eq("rst_idx", {30'h0, coeff_index}, 0);
    check_eq("rst_done", {31'h0, coeff_done}, 0);
    check_eq("rst_overrun", {31'h0, overrun}, 0);
    check_eq("rst_sample_out", {16'h0, sample_out}, 0);

    // Single sample, controller idle
    push_one(16'h1234);
    check_eq("t1_count_after_push", {29'h0, fifo_count}, 1);
    check_eq("t1_dr_c1", {31'h0, data_ready}, 0);
    tick();
    check_eq("t1_dr_c2", {31'h0, data_ready}, 1);
    check_eq("t1_out_c2", {16'h0, sample_out}, 32'h1234);
    tick();
    check_eq("t1_dr_c3", {31'h0, data_ready}, 1);
    check_eq("t1_out_c3", {16'h0, sample_out}, 32'h1234);
    check_eq("t1_count_c3", {29'h0, fifo_count}, 1);
    tick();
    check_eq("t1_dr_c4", {31'h0, data_ready}, 0);
    check_eq("t1_count_c4", {29'h0, fifo_count}, 0);
    repeat (2) tick();

    // Overfill with controller busy
    mw_man = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      push_one(16'hA000 + 16'(v));
      check_eq($sformatf("t2_ready_after_push%0d", v), {31'h0, sample_ready},
               (v < 4) ? 32'h1 : 32'h0);
    end
    check_eq("t2_count_full", {29'h0, fifo_count}, 4);
    check_eq("t2_overrun_set", {31'h0, overrun}, 1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check_eq("t2_overrun_cleared", {31'h0, overrun}, 0);
    clear_overrun = 1'b1;
    push_one(16'h0BAD);
    clear_overrun = 1'b0;
    check_eq("t2_set_beats_clear", {31'h0, overrun}, 1);
    check_eq("t2_count_still_full", {29'h0, fifo_count}, 4);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check_eq("t2_overrun_cleared2", {31'h0, overrun}, 0);
    ev_q.delete();
    auto_ctrl = 1'b1;
    repeat (40) tick();
    exp_q.delete();
    for (int v = 1; v <= 4; v++) exp_q.push_back(32'hA000 + v);
    check_events("t2_drain");
    check_eq("t2_count_empty", {29'h0, fifo_count}, 0);

    // Coefficient load with samples queued
    auto_ctrl = 1'b0;
    mw_man = 1'b1;
    push_one(16'hB001);
    push_one(16'hB002);
    ev_q.delete();
    new_coeff_set = 1'b1;
    busy = 0;
    auto_ctrl = 1'b1;
    repeat (70) tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0001_0000 + i);
    exp_q.push_back(32'h0002_0000);
    exp_q.push_back(32'hB001);
    exp_q.push_back(32'hB002);
    check_events("t3_coeff");
    check_eq("t3_idx_back_to_0", {30'h0, coeff_index}, 0);
    check_eq("t3_count_empty", {29'h0, fifo_count}, 0);

    // Error during SWAIT releases the sequencer
    auto_ctrl = 1'b0;
    mw_man = 1'b1;
    push_one(16'hC001);
    push_one(16'hC002);
    mw_man = 1'b0;
    tick();
    check_eq("t4_dr1", {31'h0, data_ready}, 1);
    check_eq("t4_out1", {16'h0, sample_out}, 32'hC001);
    mw_man = 1'b1;
    tick();
    tick();
    check_eq("t4_swait_dr", {31'h0, data_ready}, 0);
    check_eq("t4_swait_count", {29'h0, fifo_count}, 1);
    tick();
    check_eq("t4_swait_holds", {31'h0, data_ready}, 0);
    err = 1'b1;
    tick();
    check_eq("t4_idle_dr", {31'h0, data_ready}, 0);
    tick();
    check_eq("t4_next_dr", {31'h0, data_ready}, 1);
    check_eq("t4_next_out", {16'h0, sample_out}, 32'hC002);
    err = 1'b0;
    mw_man = 1'b0;
    repeat (4) tick();
    check_eq("t4_count_empty", {29'h0, fifo_count}, 0);

    // Push and pop in the same cycle, then order across pointer wrap
    mw_man = 1'b1;
    ev_q.delete();
    push_one(16'h0001);
    push_one(16'h0002);
    mw_man = 1'b0;
    tick();
    check_eq("t5_dr1", {31'h0, data_ready}, 1);
    mw_man = 1'b1;
    tick();
    push_one(16'h0003);
    check_eq("t5_push_pop_count", {29'h0, fifo_count}, 2);
    busy = 3;
    auto_ctrl = 1'b1;
    for (int v = 4; v <= 10; v++) begin
      int guard = 0;
      while (!sample_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check_eq("t5_ready_wait", {31'h0, sample_ready}, 1);
      push_one(16'(v));
    end
    repeat (80) tick();
    exp_q.delete();
    for (int v = 1; v <= 10; v++) exp_q.push_back(v);
    check_events("t5_wrap_order");
    check_eq("t5_count_empty", {29'h0, fifo_count}, 0);

    // Reset asserted during DR1
    auto_ctrl = 1'b0;
    mw_man = 1'b1;
    push_one(16'hE001);
    mw_man = 1'b0;
    tick();
    check_eq("t6_dr1", {31'h0, data_ready}, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("t6_rst_dr", {31'h0, data_ready}, 0);
    check_eq("t6_rst_count", {29'h0, fifo_count}, 0);
    check_eq("t6_rst_ready", {31'h0, sample_ready}, 1);
    check_eq("t6_rst_out", {16'h0, sample_out}, 0);
    prev_dr = 1'b0;
    prev_lc = 1'b0;
    dr_len = 0;
    #2;
    n_rst = 1'b1;
    tick();
    check_eq("t6_post_dr", {31'h0, data_ready}, 0);
    check_eq("t6_post_lc", {31'h0, load_coeff}, 0);
    check_eq("t6_post_count", {29'h0, fifo_count}, 0);
    repeat (3) tick();
    check_eq("t6_idle_dr", {31'h0, data_ready}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
